// File: rtl/pcie_fc_pkg.sv
// Shared types and constants for the PCIe flow-control credit sampler.
// Holds the cfg_fc_sel view codes, credit field widths and the output record layout.
package pcie_fc_pkg;

  localparam int HDR_W = 8;
  localparam int DAT_W = 12;

  localparam logic [2:0] FC_SEL_RX_AVAIL = 3'b000;
  localparam logic [2:0] FC_SEL_RX_LIMIT = 3'b001;
  localparam logic [2:0] FC_SEL_RX_CONS  = 3'b010;
  localparam logic [2:0] FC_SEL_TX_AVAIL = 3'b100;
  localparam logic [2:0] FC_SEL_TX_LIMIT = 3'b101;
  localparam logic [2:0] FC_SEL_TX_CONS  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUT    = 2'd2
  } fc_state_t;

  typedef struct packed {
    logic [2:0]       sel;
    logic [7:0]       sweep;
    logic [HDR_W-1:0] ph;
    logic [HDR_W-1:0] nph;
    logic [HDR_W-1:0] cplh;
    logic [DAT_W-1:0] pd;
    logic [DAT_W-1:0] npd;
    logic [DAT_W-1:0] cpld;
  } fc_rec_t;

  // {found, index} of the lowest set mask bit strictly above 'from'; from = -1 yields the first view.
  function automatic logic [3:0] next_view(input logic [7:0] mask, input int from);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (i > from)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/pcie_fc_sampler_if.sv
// Output record stream of the flow-control sampler.
// Handshake: a record transfers on a clock edge where m_fc_valid and m_fc_ready are both high;
// once valid is raised, valid and every payload field hold steady until that transfer edge.
interface pcie_fc_sampler_if;

  logic                         m_fc_valid;
  logic                         m_fc_ready;
  logic [2:0]                   m_fc_sel;
  logic [7:0]                   m_fc_sweep;
  logic [pcie_fc_pkg::HDR_W-1:0] m_fc_ph;
  logic [pcie_fc_pkg::HDR_W-1:0] m_fc_nph;
  logic [pcie_fc_pkg::HDR_W-1:0] m_fc_cplh;
  logic [pcie_fc_pkg::DAT_W-1:0] m_fc_pd;
  logic [pcie_fc_pkg::DAT_W-1:0] m_fc_npd;
  logic [pcie_fc_pkg::DAT_W-1:0] m_fc_cpld;

  modport master (
    output m_fc_valid, m_fc_sel, m_fc_sweep,
    output m_fc_ph, m_fc_nph, m_fc_cplh, m_fc_pd, m_fc_npd, m_fc_cpld,
    input  m_fc_ready
  );

  modport slave (
    input  m_fc_valid, m_fc_sel, m_fc_sweep,
    input  m_fc_ph, m_fc_nph, m_fc_cplh, m_fc_pd, m_fc_npd, m_fc_cpld,
    output m_fc_ready
  );

endinterface

// File: rtl/pcie_fc_watermark.sv
// Six independent low-watermark registers for one credit view.
// A load takes priority over a clear: a coincident clear simply restarts the minimum from the loaded value.
module pcie_fc_watermark
  import pcie_fc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [HDR_W-1:0] ph,
  input  logic [HDR_W-1:0] nph,
  input  logic [HDR_W-1:0] cplh,
  input  logic [DAT_W-1:0] pd,
  input  logic [DAT_W-1:0] npd,
  input  logic [DAT_W-1:0] cpld,
  output logic [HDR_W-1:0] wm_ph,
  output logic [HDR_W-1:0] wm_nph,
  output logic [HDR_W-1:0] wm_cplh,
  output logic [DAT_W-1:0] wm_pd,
  output logic [DAT_W-1:0] wm_npd,
  output logic [DAT_W-1:0] wm_cpld
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wm_ph   <= '1;
      wm_nph  <= '1;
      wm_cplh <= '1;
      wm_pd   <= '1;
      wm_npd  <= '1;
      wm_cpld <= '1;
    end else if (load) begin
      wm_ph   <= (clear || (ph   < wm_ph))   ? ph   : wm_ph;
      wm_nph  <= (clear || (nph  < wm_nph))  ? nph  : wm_nph;
      wm_cplh <= (clear || (cplh < wm_cplh)) ? cplh : wm_cplh;
      wm_pd   <= (clear || (pd   < wm_pd))   ? pd   : wm_pd;
      wm_npd  <= (clear || (npd  < wm_npd))  ? npd  : wm_npd;
      wm_cpld <= (clear || (cpld < wm_cpld)) ? cpld : wm_cpld;
    end else if (clear) begin
      wm_ph   <= '1;
      wm_nph  <= '1;
      wm_cplh <= '1;
      wm_pd   <= '1;
      wm_npd  <= '1;
      wm_cpld <= '1;
    end
  end

endmodule

// File: rtl/pcie_fc_sampler.sv
// Sweeps cfg_fc_sel over the views in SEL_MASK, waits for the core readback to settle,
// and emits one captured credit record per view on a valid/ready stream.
module pcie_fc_sampler
  import pcie_fc_pkg::*;
#(
  parameter logic [7:0] SEL_MASK      = 8'h21,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         PERIOD        = 1024,
  parameter int         WM_SEL        = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             trigger,
  input  logic             wm_clear,
  output logic [2:0]       cfg_fc_sel,
  input  logic [HDR_W-1:0] cfg_fc_ph,
  input  logic [HDR_W-1:0] cfg_fc_nph,
  input  logic [HDR_W-1:0] cfg_fc_cplh,
  input  logic [DAT_W-1:0] cfg_fc_pd,
  input  logic [DAT_W-1:0] cfg_fc_npd,
  input  logic [DAT_W-1:0] cfg_fc_cpld,
  pcie_fc_sampler_if.master m_fc,
  output logic [HDR_W-1:0] wm_ph,
  output logic [HDR_W-1:0] wm_nph,
  output logic [HDR_W-1:0] wm_cplh,
  output logic [DAT_W-1:0] wm_pd,
  output logic [DAT_W-1:0] wm_npd,
  output logic [DAT_W-1:0] wm_cpld,
  output logic             busy,
  output fc_state_t        dbg_state
);

  localparam logic [2:0]  FIRST_SEL   = 3'(next_view(SEL_MASK, -1));
  localparam bit          MASK_EMPTY  = (SEL_MASK == 8'h00);
  localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam bit          PERIODIC    = (PERIOD != 0);
  localparam logic [23:0] PERIOD_MAX  = 24'(PERIOD);
  // Start fires on the edge PERIOD cycles after the sweep-end edge, hence the compare against PERIOD-1.
  localparam logic [23:0] PERIOD_HIT  = PERIODIC ? 24'(PERIOD - 1) : 24'd0;

  fc_state_t   state, state_n;
  logic [7:0]  settle_cnt;
  logic [23:0] period_cnt;
  logic        pending;
  logic        valid;
  fc_rec_t     rec;

  logic        period_hit;
  logic        start, capture, advance, finish;
  logic [3:0]  nxt;
  logic        wm_load;

  assign nxt        = next_view(SEL_MASK, int'(cfg_fc_sel));
  assign period_hit = PERIODIC && enable && (period_cnt >= PERIOD_HIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    capture = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!MASK_EMPTY && (trigger || pending || period_hit)) begin
          start   = 1'b1;
          state_n = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == 8'd0) begin
          capture = 1'b1;
          state_n = ST_OUT;
        end
      end
      ST_OUT: begin
        // cfg_fc_sel only moves once the pending record is accepted.
        if (m_fc.m_fc_ready) begin
          if (nxt[3]) begin
            advance = 1'b1;
            state_n = ST_SETTLE;
          end else begin
            finish  = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_fc_sel <= FIRST_SEL;
      settle_cnt <= 8'd0;
    end else if (start) begin
      cfg_fc_sel <= FIRST_SEL;
      settle_cnt <= SETTLE_LOAD;
    end else if (advance) begin
      cfg_fc_sel <= nxt[2:0];
      settle_cnt <= SETTLE_LOAD;
    end else if ((state == ST_SETTLE) && (settle_cnt != 8'd0)) begin
      settle_cnt <= settle_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= 24'd0;
      pending    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (finish)
        period_cnt <= 24'd0;
      else if ((state == ST_IDLE) && (period_cnt != PERIOD_MAX))
        period_cnt <= period_cnt + 24'd1;

      // One-deep: a trigger arriving while the flag is already set is absorbed.
      if (start)
        pending <= 1'b0;
      else if (trigger && (state != ST_IDLE))
        pending <= 1'b1;

      if (start)       busy <= 1'b1;
      else if (finish) busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      rec   <= '0;
    end else begin
      if (capture) begin
        valid    <= 1'b1;
        rec.sel  <= cfg_fc_sel;
        rec.ph   <= cfg_fc_ph;
        rec.nph  <= cfg_fc_nph;
        rec.cplh <= cfg_fc_cplh;
        rec.pd   <= cfg_fc_pd;
        rec.npd  <= cfg_fc_npd;
        rec.cpld <= cfg_fc_cpld;
      end else if ((state == ST_OUT) && m_fc.m_fc_ready) begin
        valid <= 1'b0;
      end
      if (finish) rec.sweep <= rec.sweep + 8'd1;
    end
  end

  assign wm_load = capture && (cfg_fc_sel == 3'(WM_SEL));

  pcie_fc_watermark u_wm (
    .clk     (clk),
    .rst     (rst),
    .clear   (wm_clear),
    .load    (wm_load),
    .ph      (cfg_fc_ph),
    .nph     (cfg_fc_nph),
    .cplh    (cfg_fc_cplh),
    .pd      (cfg_fc_pd),
    .npd     (cfg_fc_npd),
    .cpld    (cfg_fc_cpld),
    .wm_ph   (wm_ph),
    .wm_nph  (wm_nph),
    .wm_cplh (wm_cplh),
    .wm_pd   (wm_pd),
    .wm_npd  (wm_npd),
    .wm_cpld (wm_cpld)
  );

  assign m_fc.m_fc_valid = valid;
  assign m_fc.m_fc_sel   = rec.sel;
  assign m_fc.m_fc_sweep = rec.sweep;
  assign m_fc.m_fc_ph    = rec.ph;
  assign m_fc.m_fc_nph   = rec.nph;
  assign m_fc.m_fc_cplh  = rec.cplh;
  assign m_fc.m_fc_pd    = rec.pd;
  assign m_fc.m_fc_npd   = rec.npd;
  assign m_fc.m_fc_cpld  = rec.cpld;
  assign dbg_state       = state;

endmodule

// File: tb/tb_pcie_fc_sampler.sv
// Bench for pcie_fc_sampler: trigger-only instance with a record scoreboard, a periodic
// instance for sweep spacing and enable behaviour, and an empty-mask instance.
module tb_pcie_fc_sampler;
  import pcie_fc_pkg::*;

  localparam int SETTLE = 4;
  localparam int REC_W  = $bits(fc_rec_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic rst_b;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0;
  int errors = 0;
  logic [REC_W-1:0] exp_q[$];
  logic [7:0] exp_sweep = 8'd0;
  logic [11:0] pd0;
  logic b_done = 1'b0;
  logic z_done = 1'b0;

  // Credit readback model of the hard core: ph = sel+10 etc., pd of view 0 is steerable.
  function automatic fc_rec_t model(input logic [2:0] sel, input logic [7:0] sw, input logic [11:0] p0);
    fc_rec_t r;
    r.sel   = sel;
    r.sweep = sw;
    r.ph    = 8'(sel) + 8'd10;
    r.nph   = 8'(sel) + 8'd20;
    r.cplh  = 8'(sel) + 8'd30;
    r.pd    = (sel == 3'd0) ? p0 : 12'(sel) + 12'd100;
    r.npd   = 12'(sel) + 12'd200;
    r.cpld  = 12'(sel) + 12'd300;
    return r;
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- DUT A: trigger-only, scoreboarded ----------------
  pcie_fc_sampler_if a_if();
  logic a_en, a_trig, a_clr, a_rdy, a_busy;
  logic [2:0] a_sel;
  logic [59:0] a_wm;
  fc_state_t a_state;
  fc_rec_t a_cred, a_act;
  always_comb a_cred = model(a_sel, 8'd0, pd0);
  assign a_if.m_fc_ready = a_rdy;
  always_comb begin
    a_act.sel   = a_if.m_fc_sel;
    a_act.sweep = a_if.m_fc_sweep;
    a_act.ph    = a_if.m_fc_ph;
    a_act.nph   = a_if.m_fc_nph;
    a_act.cplh  = a_if.m_fc_cplh;
    a_act.pd    = a_if.m_fc_pd;
    a_act.npd   = a_if.m_fc_npd;
    a_act.cpld  = a_if.m_fc_cpld;
  end

  pcie_fc_sampler #(.SEL_MASK(8'h21), .SETTLE_CYCLES(SETTLE), .PERIOD(0), .WM_SEL(0)) dut_a (
    .clk(clk), .rst(rst), .enable(a_en), .trigger(a_trig), .wm_clear(a_clr),
    .cfg_fc_sel(a_sel),
    .cfg_fc_ph(a_cred.ph), .cfg_fc_nph(a_cred.nph), .cfg_fc_cplh(a_cred.cplh),
    .cfg_fc_pd(a_cred.pd), .cfg_fc_npd(a_cred.npd), .cfg_fc_cpld(a_cred.cpld),
    .m_fc(a_if),
    .wm_ph(a_wm[59:52]), .wm_nph(a_wm[51:44]), .wm_cplh(a_wm[43:36]),
    .wm_pd(a_wm[35:24]), .wm_npd(a_wm[23:12]), .wm_cpld(a_wm[11:0]),
    .busy(a_busy), .dbg_state(a_state)
  );

  // ---------------- DUT B: PERIOD = 100 ----------------
  pcie_fc_sampler_if b_if();
  logic b_en, b_busy;
  logic [2:0] b_sel;
  logic [59:0] b_wm;
  fc_state_t b_state;
  fc_rec_t b_cred;
  int b_recs = 0;
  always_comb b_cred = model(b_sel, 8'd0, 12'd50);
  assign b_if.m_fc_ready = 1'b1;

  pcie_fc_sampler #(.SEL_MASK(8'h21), .SETTLE_CYCLES(SETTLE), .PERIOD(100), .WM_SEL(0)) dut_b (
    .clk(clk), .rst(rst_b), .enable(b_en), .trigger(1'b0), .wm_clear(1'b0),
    .cfg_fc_sel(b_sel),
    .cfg_fc_ph(b_cred.ph), .cfg_fc_nph(b_cred.nph), .cfg_fc_cplh(b_cred.cplh),
    .cfg_fc_pd(b_cred.pd), .cfg_fc_npd(b_cred.npd), .cfg_fc_cpld(b_cred.cpld),
    .m_fc(b_if),
    .wm_ph(b_wm[59:52]), .wm_nph(b_wm[51:44]), .wm_cplh(b_wm[43:36]),
    .wm_pd(b_wm[35:24]), .wm_npd(b_wm[23:12]), .wm_cpld(b_wm[11:0]),
    .busy(b_busy), .dbg_state(b_state)
  );

  // ---------------- DUT Z: empty mask ----------------
  pcie_fc_sampler_if z_if();
  logic z_trig, z_busy;
  logic [2:0] z_sel;
  logic [59:0] z_wm;
  fc_state_t z_state;
  assign z_if.m_fc_ready = 1'b1;

  pcie_fc_sampler #(.SEL_MASK(8'h00), .SETTLE_CYCLES(SETTLE), .PERIOD(10), .WM_SEL(0)) dut_z (
    .clk(clk), .rst(rst_b), .enable(1'b1), .trigger(z_trig), .wm_clear(1'b0),
    .cfg_fc_sel(z_sel),
    .cfg_fc_ph(8'd1), .cfg_fc_nph(8'd2), .cfg_fc_cplh(8'd3),
    .cfg_fc_pd(12'd4), .cfg_fc_npd(12'd5), .cfg_fc_cpld(12'd6),
    .m_fc(z_if),
    .wm_ph(z_wm[59:52]), .wm_nph(z_wm[51:44]), .wm_cplh(z_wm[43:36]),
    .wm_pd(z_wm[35:24]), .wm_npd(z_wm[23:12]), .wm_cpld(z_wm[11:0]),
    .busy(z_busy), .dbg_state(z_state)
  );

  // ---------------- scoreboard monitor for DUT A ----------------
  initial begin
    logic prev_valid, prev_ready, prev_busy;
    logic [2:0] prev_sel;
    fc_rec_t prev_rec;
    int last_sel_cyc;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_busy = 1'b0;
    prev_sel = 3'd0; prev_rec = '0; last_sel_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        prev_valid = 1'b0;
        prev_busy  = 1'b0;
        prev_sel   = a_sel;
      end else begin
        if ((a_sel !== prev_sel) || (a_busy && !prev_busy)) last_sel_cyc = cycle;
        if (a_if.m_fc_valid && !prev_valid)
          check("capture_latency", 80'(cycle - last_sel_cyc), 80'(SETTLE));
        if (prev_valid && !prev_ready) begin
          check("valid_held", 80'(a_if.m_fc_valid), 80'd1);
          check("data_stable", 80'(a_act), 80'(prev_rec));
        end
        if (a_if.m_fc_valid && a_if.m_fc_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_record: got %0h expected none", a_act);
          end else begin
            check("record", 80'(a_act), 80'(exp_q.pop_front()));
          end
        end
        prev_valid = a_if.m_fc_valid;
        prev_ready = a_if.m_fc_ready;
        prev_busy  = a_busy;
        prev_sel   = a_sel;
        prev_rec   = a_act;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_sweep();
    exp_q.push_back(REC_W'(model(3'd0, exp_sweep, pd0)));
    exp_q.push_back(REC_W'(model(3'd5, exp_sweep, pd0)));
    exp_sweep = exp_sweep + 8'd1;
  endtask

  task automatic trig_a();
    @(posedge clk); #1 a_trig = 1'b1;
    @(posedge clk); #1 a_trig = 1'b0;
  endtask

  task automatic wait_idle_a(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((a_busy !== 1'b0) && (n < 3000)) begin @(negedge clk); n++; end
    checks++;
    if (a_busy !== 1'b0) begin errors++; $display("FAIL %s: busy=%b after timeout, expected 0", name, a_busy); end
  endtask

  // what = 0: wait for m_fc_valid; what = 1: wait for cfg_fc_sel == 5
  task automatic wait_a(input int what, input string name);
    int n;
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && (n < 200)) begin
      @(negedge clk);
      hit = (what == 0) ? (a_if.m_fc_valid === 1'b1) : (a_sel === 3'd5);
      n++;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL %s: condition not reached, got 0 expected 1", name); end
  endtask

  task automatic wait_b(input logic val, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((b_busy !== val) && (n < 500)) begin @(negedge clk); n++; end
    checks++;
    if (b_busy !== val) begin errors++; $display("FAIL %s: busy=%b expected %b", name, b_busy, val); end
  endtask

  // ---------------- DUT B: period spacing and enable drop ----------------
  initial begin
    int b_starts;
    logic pb;
    b_starts = 0;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_b === 1'b0) begin
        if (b_if.m_fc_valid && b_if.m_fc_ready) b_recs++;
      end
    end
  end

  initial begin
    int t_end, t_start, n_rec, k;
    int starts_seen;
    b_en = 1'b0;
    wait (rst_b === 1'b0);
    @(posedge clk); #1 b_en = 1'b1;
    wait_b(1'b1, "b_first_start");
    for (k = 0; k < 3; k++) begin
      wait_b(1'b0, "b_end");
      t_end = cycle;
      wait_b(1'b1, "b_start");
      t_start = cycle;
      check("period_gap", 80'(t_start - t_end), 80'd100);
    end
    @(posedge clk); #1 b_en = 1'b0;
    n_rec = b_recs;
    wait_b(1'b0, "b_finish_after_disable");
    starts_seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (b_busy === 1'b1) starts_seen++;
    end
    check("b_recs_after_disable", 80'(b_recs - n_rec), 80'd2);
    check("b_no_sweep_when_disabled", 80'(starts_seen), 80'd0);
    b_done = 1'b1;
  end

  // ---------------- DUT Z: empty mask never leaves IDLE ----------------
  initial begin
    int seen;
    z_trig = 1'b0;
    seen = 0;
    wait (rst_b === 1'b0);
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #1 z_trig = ((i % 20) == 3);
      @(negedge clk);
      if ((z_busy !== 1'b0) || (z_if.m_fc_valid !== 1'b0) || (z_state !== ST_IDLE)) seen++;
    end
    z_trig = 1'b0;
    check("mask0_never_busy", 80'(seen), 80'd0);
    check("mask0_cfg_sel", 80'(z_sel), 80'd0);
    z_done = 1'b1;
  end

  // ---------------- main stimulus for DUT A ----------------
  initial begin
    logic [11:0] pd_seq [3];
    pd_seq[0] = 12'd300; pd_seq[1] = 12'd120; pd_seq[2] = 12'd400;
    rst = 1'b1; rst_b = 1'b1;
    a_en = 1'b0; a_trig = 1'b0; a_clr = 1'b0; a_rdy = 1'b1; pd0 = 12'd200;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    check("rst_cfg_sel", 80'(a_sel), 80'd0);
    check("rst_valid", 80'(a_if.m_fc_valid), 80'd0);
    check("rst_busy", 80'(a_busy), 80'd0);
    check("rst_record", 80'(a_act), 80'd0);
    check("rst_wm", 80'(a_wm), 80'hFFF_FFFF_FFFF_FFFF);
    check("rst_state", 80'(a_state), 80'(ST_IDLE));

    // single triggered sweep: sel 0 (ph 10) then sel 5 (ph 15)
    push_sweep();
    trig_a();
    wait_idle_a("sweep1_done");
    check("sweep_cnt_1", 80'(a_if.m_fc_sweep), 80'd1);
    check("sweep1_queue_empty", 80'(exp_q.size()), 80'd0);

    // 50 cycles of backpressure on the first record
    a_rdy = 1'b0;
    push_sweep();
    trig_a();
    wait_a(0, "bp_valid_rise");
    repeat (50) @(negedge clk);
    check("bp_cfg_sel_held", 80'(a_sel), 80'd0);
    check("bp_valid_high", 80'(a_if.m_fc_valid), 80'd1);
    @(posedge clk); #1 a_rdy = 1'b1;
    wait_idle_a("bp_done");
    check("sweep_cnt_2", 80'(a_if.m_fc_sweep), 80'd2);

    // three triggers in one sweep: exactly one extra sweep
    push_sweep();
    push_sweep();
    trig_a();
    trig_a();
    trig_a();
    repeat (60) @(negedge clk);
    check("pend_idle", 80'(a_busy), 80'd0);
    check("pend_queue_empty", 80'(exp_q.size()), 80'd0);
    check("sweep_cnt_4", 80'(a_if.m_fc_sweep), 80'd4);

    // run to the 255 -> 0 wrap
    while (exp_sweep != 8'd0) begin
      if (exp_sweep == 8'd255) check("sweep_cnt_255", 80'(a_if.m_fc_sweep), 80'd255);
      push_sweep();
      trig_a();
      wait_idle_a("wrap_sweep");
    end
    check("sweep_wrap_0", 80'(a_if.m_fc_sweep), 80'd0);

    // watermarks
    @(posedge clk); #1 a_clr = 1'b1;
    @(posedge clk); #1 a_clr = 1'b0;
    @(negedge clk);
    check("wm_clear_pd", 80'(a_wm[35:24]), 80'hFFF);
    for (int i = 0; i < 3; i++) begin
      pd0 = pd_seq[i];
      push_sweep();
      trig_a();
      wait_idle_a("wm_sweep");
    end
    check("wm_pd_min", 80'(a_wm[35:24]), 80'd120);
    check("wm_ph_min", 80'(a_wm[59:52]), 80'd10);
    check("wm_npd_min", 80'(a_wm[23:12]), 80'd200);

    pd0 = 12'd90;
    push_sweep();
    trig_a();
    repeat (3) @(posedge clk);
    #1 a_clr = 1'b1;
    @(posedge clk); #1 a_clr = 1'b0;
    wait_idle_a("wm_clr90");
    check("wm_clear_load_90", 80'(a_wm[35:24]), 80'd90);

    pd0 = 12'd500;
    push_sweep();
    trig_a();
    repeat (3) @(posedge clk);
    #1 a_clr = 1'b1;
    @(posedge clk); #1 a_clr = 1'b0;
    wait_idle_a("wm_clr500");
    check("wm_clear_load_500", 80'(a_wm[35:24]), 80'd500);
    check("wm_ph_after_clear_load", 80'(a_wm[59:52]), 80'd10);

    // asynchronous reset while settling on view 5
    push_sweep();
    trig_a();
    wait_a(1, "rst_settle_sel5");
    @(posedge clk); #2 rst = 1'b1;
    exp_q.delete();
    exp_sweep = 8'd0;
    #1;
    check("rst_settle_cfg_sel", 80'(a_sel), 80'd0);
    check("rst_settle_busy", 80'(a_busy), 80'd0);
    check("rst_settle_sweep", 80'(a_if.m_fc_sweep), 80'd0);
    check("rst_settle_wm", 80'(a_wm), 80'hFFF_FFFF_FFFF_FFFF);
    check("rst_settle_state", 80'(a_state), 80'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push_sweep();
    trig_a();
    wait_idle_a("post_rst1_sweep");
    check("post_rst1_sweep_cnt", 80'(a_if.m_fc_sweep), 80'd1);

    // asynchronous reset while a record is stalled
    a_rdy = 1'b0;
    push_sweep();
    trig_a();
    wait_a(0, "rst_out_valid");
    @(posedge clk); #2 rst = 1'b1;
    exp_q.delete();
    exp_sweep = 8'd0;
    #1;
    check("rst_out_valid", 80'(a_if.m_fc_valid), 80'd0);
    check("rst_out_record", 80'(a_act), 80'd0);
    check("rst_out_busy", 80'(a_busy), 80'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; a_rdy = 1'b1;
    push_sweep();
    trig_a();
    wait_idle_a("post_rst2_sweep");
    check("post_rst2_sweep_cnt", 80'(a_if.m_fc_sweep), 80'd1);

    for (int i = 0; (i < 5000) && !(b_done && z_done); i++) @(negedge clk);
    check("side_benches_done", 80'({b_done, z_done}), 80'b11);
    check("final_queue_empty", 80'(exp_q.size()), 80'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcie_fc_sampler.md
# pcie_fc_sampler

Periodic sampler for the PCIe hard core's flow-control credit counters. It time-multiplexes the core's `cfg_fc_sel` input across a parametrised set of credit views, and waits for the core's readback pipeline to settle. It then captures all six credit fields per view and emits one record per view on a ready/valid stream, while tracking low-watermarks for one designated view. It sits in the `fpga_core` user-clock domain between the core's `cfg_fc_*` port and the DMA benchmark statistics logic. It replaces the single hard-wired `cfg_fc_sel` tie-off.

## Interface
Parameters:
- `SEL_MASK`, 8'h21: bit n set means `cfg_fc_sel` = n is included in the sweep. Views are swept in ascending n.
- `SETTLE_CYCLES`, 4: cycles from a `cfg_fc_sel` change to capture. Legal range is 1–255.
- `PERIOD`, 1024: cycles from the end of one sweep to the start of the next. 0 means trigger-only; legal range is 0–2^24-1.
- `WM_SEL`, 0: view whose fields feed the low-watermark registers. It must be a set bit in `SEL_MASK`.

Ports:
- `clk` in 1: PCIe user clock, 250 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: permits periodic sweeps.
- `trigger` in 1: single-cycle pulse that requests an immediate sweep.
- `wm_clear` in 1: single-cycle pulse that resets the watermarks.
- `cfg_fc_sel` out 3: view selection driven to the core. Registered.
- `cfg_fc_ph`, `cfg_fc_nph`, `cfg_fc_cplh` in 8 each: header credits.
- `cfg_fc_pd`, `cfg_fc_npd`, `cfg_fc_cpld` in 12 each: data credits.
- `m_fc_valid` out 1 / `m_fc_ready` in 1: output record handshake.
- `m_fc_sel` out 3, `m_fc_sweep` out 8: view of the record and sweep sequence number.
- `m_fc_ph`, `m_fc_nph`, `m_fc_cplh` out 8; `m_fc_pd`, `m_fc_npd`, `m_fc_cpld` out 12: captured credit values.
- `wm_ph`, `wm_nph`, `wm_cplh` out 8; `wm_pd`, `wm_npd`, `wm_cpld` out 12: minimum value seen for view `WM_SEL` since the last clear.
- `busy` out 1: high while a sweep is in progress.

## Operation
- States:
  - IDLE: wait for a sweep request.
  - SETTLE: `cfg_fc_sel` holds the current view; the settle counter runs.
  - OUT: a record is presented and held until accepted.
  - After OUT, go to SETTLE for the next set bit, or to IDLE if none remain.
- Sweep start occurs on any of:
  - the period counter reaching `PERIOD` while `enable` is high;
  - `trigger`;
  - a pending trigger.
- `trigger` during a sweep sets a one-deep pending flag. Further triggers while the flag is set are ignored.
- The period counter clears at sweep end, counts only in IDLE, and saturates at `PERIOD`.
- `enable` falling mid-sweep does not abort the sweep. The current sweep completes, then the block idles.
- `m_fc_sweep` increments by 1 at each sweep end, wrapping 255 to 0. All records of one sweep carry the same value.
- Capture loads all six fields simultaneously into the output registers.
- If the captured view is `WM_SEL`, each watermark is updated to min(wm, captured) independently.
- `wm_clear` sets all watermarks to all-ones (8'hFF / 12'hFFF). If `wm_clear` coincides with a `WM_SEL` capture, the watermarks load the captured values.
- `SEL_MASK` = 0: the block never leaves IDLE, `busy` stays 0, and triggers are dropped.

## Timing
- Reset values:
  - `cfg_fc_sel` = lowest set bit of `SEL_MASK` (0 if the mask is empty).
  - `m_fc_valid`, `busy`, `m_fc_sweep`, and all `m_fc_*` data = 0.
  - Watermarks = all-ones.
  - State = IDLE; period counter = 0; pending flag = 0.
- Reset may assert in any state. Any in-flight record is dropped, and the stream restarts cleanly after reset release.
- `busy` rises on the edge that leaves IDLE. It falls on the edge that accepts the last record.
- When `cfg_fc_sel` changes at edge N, capture happens at edge N+`SETTLE_CYCLES`, and `m_fc_valid` is high from that edge on.
- `cfg_fc_sel` is never changed while a record is pending. Backpressure therefore stalls the sweep, not the core readback.
- AXI-stream rules apply:
  - `m_fc_valid` never drops without `m_fc_ready`.
  - Data is stable while valid.
  - Transfer occurs when valid and ready are both high.
- After acceptance, `cfg_fc_sel` advances on the same edge. The minimum record spacing is therefore `SETTLE_CYCLES` cycles.

## Structure
- Package `pcie_fc_pkg`:
  - `cfg_fc_sel` encoding constants: RX available, RX limit, RX consumed, TX consumed, TX available, TX limit.
  - Header and data width localparams (8 and 12).
  - A record struct type.
- One sub-module, `pcie_fc_watermark`: six min-registers with clear and load-priority logic. The FSM, settle counter, and period counter stay in the top level.

## Test plan
- `SEL_MASK`=8'h21, `PERIOD`=0, `SETTLE_CYCLES`=4, pulse `trigger`, credit model returns ph=sel+10: expect two records, sel 0 (ph=10) then sel 5 (ph=15). Each capture is exactly 4 cycles after the `cfg_fc_sel` change, and `m_fc_sweep`=1 after the sweep.
- Hold `m_fc_ready` low for 50 cycles during the first record: expect valid and data stable, `cfg_fc_sel` unchanged, and no loss.
- `PERIOD`=100, `enable`=1: expect sweep starts 100 IDLE cycles apart. Drop `enable` mid-sweep: expect the sweep to finish and no further sweeps.
- Two `trigger` pulses mid-sweep: expect exactly one extra sweep. `m_fc_sweep` wraps from 255 to 0 after 256 sweeps.
- `WM_SEL`=0, sample pd sequence 300, 120, 400: expect `wm_pd`=120. Apply `wm_clear` together with a capture of 90: expect `wm_pd`=90.
- Assert `rst` asynchronously in SETTLE and in OUT: expect all outputs at their reset values within the same cycle, and a normal sweep on the next trigger.
